// File: rtl/multiplier_arbiter_tainttrack.sv
// Round-robin arbiter that shares one sequential multiplier between NREQ
// requesters. Each data/control signal has a parallel _t taint signal that
// OR-propagates through the arbitration decision and the datapath.
//
// Ports
//   clk, rst                         clock, synchronous active-low reset
//   req / req_t                      request level per requester (+ taint)
//   req_a, req_b (+ _t)              packed operands, slot i at [i*WIDTH +: WIDTH]
//   grant / grant_t                  one-hot owner during ISSUE..RESP
//   resp_valid / resp_valid_t        one-cycle pulse to the owner
//   resp_product / resp_product_t    product, holds after the response
//   mul_start / mul_start_t          start pulse to the multiplier
//   mul_a, mul_b (+ _t)              operands latched at grant time
//   mul_done / mul_done_t            completion flag from the multiplier
//   mul_product / mul_product_t      multiplier result
module multiplier_arbiter_tainttrack #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_t,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_a_t,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*WIDTH-1:0]   req_b_t,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         grant_t,
    output logic [NREQ-1:0]         resp_valid,
    output logic [NREQ-1:0]         resp_valid_t,
    output logic [2*WIDTH-1:0]      resp_product,
    output logic [2*WIDTH-1:0]      resp_product_t,
    output logic                    mul_start,
    output logic                    mul_start_t,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_a_t,
    output logic [WIDTH-1:0]        mul_b,
    output logic [WIDTH-1:0]        mul_b_t,
    input  logic                    mul_done,
    input  logic                    mul_done_t,
    input  logic [2*WIDTH-1:0]      mul_product,
    input  logic [2*WIDTH-1:0]      mul_product_t
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             r_state;
    logic               r_state_t;
    logic [IDXW-1:0]    r_rr_ptr;
    logic [IDXW-1:0]    r_owner;
    logic               r_owner_t;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_grant_t;
    logic [NREQ-1:0]    r_resp_valid;
    logic [NREQ-1:0]    r_resp_valid_t;
    logic [PW-1:0]      r_resp_product;
    logic [PW-1:0]      r_resp_product_t;
    logic               r_mul_start;
    logic               r_mul_start_t;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_a_t;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   r_mul_b_t;

    logic [WIDTH-1:0]   w_a   [NREQ];
    logic [WIDTH-1:0]   w_a_t [NREQ];
    logic [WIDTH-1:0]   w_b   [NREQ];
    logic [WIDTH-1:0]   w_b_t [NREQ];
    logic [IDXW-1:0]    w_pick;
    logic [NREQ-1:0]    w_pick_oh;
    logic [NREQ-1:0]    w_own_oh;
    logic [IDXW-1:0]    w_next_ptr;
    logic               w_any_req_t;
    logic               w_wait_st_t;

    // Unpack the flat operand buses into per-requester slots
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g]   = req_a[g*WIDTH +: WIDTH];
        assign w_a_t[g] = req_a_t[g*WIDTH +: WIDTH];
        assign w_b[g]   = req_b[g*WIDTH +: WIDTH];
        assign w_b_t[g] = req_b_t[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: scanning from the highest offset down leaves the
    // closest requester at or after rr_ptr as the final assignment
    always_comb begin
        int k;
        k      = 0;
        w_pick = r_rr_ptr;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            k = (int'(r_rr_ptr) + i) % int'(NREQ);
            if (req[IDXW'(k)]) begin
                w_pick = IDXW'(k);
            end
        end
    end

    assign w_pick_oh   = NREQ'(1) << w_pick;
    assign w_own_oh    = NREQ'(1) << r_owner;
    assign w_next_ptr  = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);
    // The arbitration decision depends on every request bit
    assign w_any_req_t = |req_t;
    assign w_wait_st_t = r_state_t | mul_done_t;

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_state_t        <= 1'b0;
            r_rr_ptr         <= '0;
            r_owner          <= '0;
            r_owner_t        <= 1'b0;
            r_grant          <= '0;
            r_grant_t        <= '0;
            r_resp_valid     <= '0;
            r_resp_valid_t   <= '0;
            r_resp_product   <= '0;
            r_resp_product_t <= '0;
            r_mul_start      <= 1'b0;
            r_mul_start_t    <= 1'b0;
            r_mul_a          <= '0;
            r_mul_a_t        <= '0;
            r_mul_b          <= '0;
            r_mul_b_t        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state_t <= w_any_req_t;
                    if (|req) begin
                        r_state       <= S_ISSUE;
                        r_owner       <= w_pick;
                        r_owner_t     <= w_any_req_t;
                        r_mul_a       <= w_a[w_pick];
                        r_mul_a_t     <= w_a_t[w_pick] | {WIDTH{w_any_req_t}};
                        r_mul_b       <= w_b[w_pick];
                        r_mul_b_t     <= w_b_t[w_pick] | {WIDTH{w_any_req_t}};
                        r_grant       <= w_pick_oh;
                        r_grant_t     <= w_pick_oh & {NREQ{w_any_req_t}};
                        r_mul_start   <= 1'b1;
                        r_mul_start_t <= w_any_req_t;
                    end
                end
                S_ISSUE: begin
                    r_state       <= S_WAIT;
                    r_mul_start   <= 1'b0;
                    r_mul_start_t <= 1'b0;
                end
                S_WAIT: begin
                    r_state_t <= w_wait_st_t;
                    r_grant_t <= w_own_oh & {NREQ{w_wait_st_t | r_owner_t}};
                    if (mul_done) begin
                        r_state          <= S_RESP;
                        r_resp_valid     <= w_own_oh;
                        r_resp_valid_t   <= w_own_oh & {NREQ{w_wait_st_t | r_owner_t}};
                        r_resp_product   <= mul_product;
                        r_resp_product_t <= mul_product_t | {PW{w_wait_st_t | r_owner_t}};
                    end
                end
                S_RESP: begin
                    r_state        <= S_IDLE;
                    r_state_t      <= 1'b0;
                    r_rr_ptr       <= w_next_ptr;
                    r_grant        <= '0;
                    r_grant_t      <= '0;
                    r_resp_valid   <= '0;
                    r_resp_valid_t <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign grant_t        = r_grant_t;
    assign resp_valid     = r_resp_valid;
    assign resp_valid_t   = r_resp_valid_t;
    assign resp_product   = r_resp_product;
    assign resp_product_t = r_resp_product_t;
    assign mul_start      = r_mul_start;
    assign mul_start_t    = r_mul_start_t;
    assign mul_a          = r_mul_a;
    assign mul_a_t        = r_mul_a_t;
    assign mul_b          = r_mul_b;
    assign mul_b_t        = r_mul_b_t;

endmodule

// File: tb/tb_multiplier_arbiter_tainttrack.sv
// Self-checking bench for multiplier_arbiter_tainttrack: a behavioural
// multiplier answers mul_start after a random delay, and a round-robin
// reference model predicts owners, products and taints.
module tb_multiplier_arbiter_tainttrack;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int PW = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, req_t;
    logic [N*W-1:0]  req_a, req_a_t, req_b, req_b_t;
    logic [N-1:0]    grant, grant_t, resp_valid, resp_valid_t;
    logic [PW-1:0]   resp_product, resp_product_t;
    logic            mul_start, mul_start_t;
    logic [W-1:0]    mul_a, mul_a_t, mul_b, mul_b_t;
    logic            mul_done, mul_done_t;
    logic [PW-1:0]   mul_product, mul_product_t;

    int checks, errors;
    int cyc, done_cyc, mdelay, ref_ptr;
    bit force_done;
    logic [PW-1:0] prod_t_cfg;

    typedef struct {
        logic [N-1:0]  g, g_t, g_resp, rv, rv_t;
        logic [W-1:0]  ma, mb, ma_t, mb_t;
        logic [PW-1:0] prod, prod_t;
        int            starts, gtick, lat;
        bit            timeout, any_t;
    } obs_t;

    multiplier_arbiter_tainttrack #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_t(req_t),
        .req_a(req_a), .req_a_t(req_a_t), .req_b(req_b), .req_b_t(req_b_t),
        .grant(grant), .grant_t(grant_t),
        .resp_valid(resp_valid), .resp_valid_t(resp_valid_t),
        .resp_product(resp_product), .resp_product_t(resp_product_t),
        .mul_start(mul_start), .mul_start_t(mul_start_t),
        .mul_a(mul_a), .mul_a_t(mul_a_t), .mul_b(mul_b), .mul_b_t(mul_b_t),
        .mul_done(mul_done), .mul_done_t(mul_done_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

    // Round-robin reference: first requester at ptr, ptr+1, ... modulo N
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        int idx;
        for (int off = 0; off < N; off++) begin
            idx = (ptr + off) % N;
            if (r[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    // One clock: sample point is the falling edge; also runs the multiplier model
    task automatic tick();
        @(negedge clk);
        cyc++;
        mul_done = force_done;
        if (mdelay > 0) begin
            mdelay--;
            if (mdelay == 0) begin
                mul_done      = 1'b1;
                mul_product   = PW'(mul_a) * PW'(mul_b);
                mul_product_t = prod_t_cfg;
                done_cyc      = cyc;
            end
        end
        if (mul_start) mdelay = $urandom_range(3, 1);
    endtask

    // Runs one arbitration cycle from the current req and records what was seen
    task automatic run_txn(input bit clr, input bit drop, input bit chg, output obs_t o);
        bit seen_g, modded;
        o.g = '0; o.g_t = '0; o.g_resp = '0; o.rv = '0; o.rv_t = '0;
        o.ma = '0; o.mb = '0; o.ma_t = '0; o.mb_t = '0; o.prod = '0; o.prod_t = '0;
        o.starts = 0; o.gtick = 0; o.lat = 0; o.timeout = 1'b1; o.any_t = 1'b0;
        seen_g = 1'b0; modded = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (mul_start) o.starts++;
            if (!seen_g && grant != '0) begin
                seen_g = 1'b1;
                o.g = grant; o.g_t = grant_t; o.gtick = t;
                o.ma = mul_a; o.mb = mul_b; o.ma_t = mul_a_t; o.mb_t = mul_b_t;
            end else if (seen_g && grant != '0 && !mul_start && resp_valid == '0 && !modded) begin
                modded = 1'b1;
                if (drop) req = '0;
                if (chg) begin req_a = ~req_a; req_b = ~req_b; end
            end
            if (seen_g) o.any_t |= (|{grant_t, resp_valid_t, mul_start_t, mul_a_t, mul_b_t});
            if (resp_valid != '0) begin
                o.rv = resp_valid; o.rv_t = resp_valid_t; o.g_resp = grant;
                o.prod = resp_product; o.prod_t = resp_product_t;
                o.any_t |= (|resp_product_t);
                o.lat = cyc - done_cyc; o.timeout = 1'b0;
                if (clr) req = '0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; req_a = 16'($urandom); req_b = 16'($urandom);
        tick(); tick();
        checks++;
        if ({grant, grant_t, resp_valid, resp_valid_t, mul_start, mul_start_t} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got %h, required 0", {grant, grant_t, resp_valid, resp_valid_t, mul_start, mul_start_t});
        end
        checks++;
        if ({mul_a, mul_b, mul_a_t, mul_b_t, resp_product, resp_product_t} !== '0) begin
            errors++; $display("FAIL reset_data: got %h, required 0", {mul_a, mul_b, mul_a_t, mul_b_t, resp_product, resp_product_t});
        end
        req = '0; rst = 1'b1; ref_ptr = 0;
        tick();
        checks++;
        if ({grant, resp_valid, mul_start} !== '0) begin
            errors++; $display("FAIL reset_idle: got %h, required 0", {grant, resp_valid, mul_start});
        end
    endtask

    task automatic test_single();
        obs_t o;
        req_a = 16'($urandom); req_b = 16'($urandom);
        req_a[2*W +: W] = 4'd3; req_b[2*W +: W] = 4'd5;
        req = 4'b0100;
        run_txn(1'b1, 1'b0, 1'b0, o);
        checks++; if (o.timeout) begin errors++; $display("FAIL single_timeout: no resp_valid, required one within 40 cycles"); end
        checks++; if (o.g !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b, required 0100", o.g); end
        checks++; if (o.gtick !== 1) begin errors++; $display("FAIL single_grant_latency: got %0d, required 1", o.gtick); end
        checks++; if (o.starts !== 1) begin errors++; $display("FAIL single_start_cycles: got %0d, required 1", o.starts); end
        checks++; if ({o.ma, o.mb} !== {4'd3, 4'd5}) begin errors++; $display("FAIL single_operands: got a=%0d b=%0d, required 3 5", o.ma, o.mb); end
        checks++; if (o.rv !== 4'b0100) begin errors++; $display("FAIL single_resp_valid: got %b, required 0100", o.rv); end
        checks++; if (o.g_resp !== 4'b0100) begin errors++; $display("FAIL single_grant_in_resp: got %b, required 0100", o.g_resp); end
        checks++; if (o.prod !== 8'd15) begin errors++; $display("FAIL single_product: got %0d, required 15", o.prod); end
        checks++; if (o.lat !== 1) begin errors++; $display("FAIL single_resp_latency: got %0d, required 1", o.lat); end
        ref_ptr = 3;
    endtask

    task automatic test_fairness();
        obs_t o;
        int w;
        logic [PW-1:0] e;
        rst = 1'b0; tick(); rst = 1'b1; ref_ptr = 0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            req_a = 16'($urandom); req_b = 16'($urandom);
            w = rr_pick(req, ref_ptr);
            e = PW'(req_a[w*W +: W]) * PW'(req_b[w*W +: W]);
            run_txn(1'b0, 1'b0, 1'b0, o);
            checks++;
            if (o.g !== 4'(1 << w) || o.rv !== 4'(1 << w)) begin
                errors++; $display("FAIL fair_grant[%0d]: got grant %b resp %b, required %b", i, o.g, o.rv, 4'(1 << w));
            end
            checks++;
            if (o.prod !== e) begin errors++; $display("FAIL fair_product[%0d]: got %0d, required %0d", i, o.prod, e); end
            ref_ptr = (w + 1) % N;
        end
        req = '0;
    endtask

    task automatic test_taint();
        obs_t o;
        req_t = 4'b0001; req_a_t = '0; req_b_t = '0; prod_t_cfg = '0; mul_done_t = 1'b0;
        req = 4'b0010;
        run_txn(1'b1, 1'b0, 1'b0, o);
        checks++; if (o.g_t !== 4'b0010) begin errors++; $display("FAIL taint_grant: got %b, required 0010", o.g_t); end
        checks++; if ({o.ma_t, o.mb_t} !== 8'hFF) begin errors++; $display("FAIL taint_operands: got %h, required ff", {o.ma_t, o.mb_t}); end
        checks++; if (o.rv_t !== 4'b0010 || o.prod_t !== 8'hFF) begin
            errors++; $display("FAIL taint_resp: got rv_t %b prod_t %h, required 0010 ff", o.rv_t, o.prod_t);
        end
        req_t = '0; req = 4'b0010;
        run_txn(1'b1, 1'b0, 1'b0, o);
        checks++; if (o.any_t !== 1'b0 || o.timeout) begin errors++; $display("FAIL taint_clean: got any_t %0d timeout %0d, required 0 0", o.any_t, o.timeout); end
        mul_done_t = 1'b1; req = 4'b0010;
        run_txn(1'b1, 1'b0, 1'b0, o);
        checks++; if (o.g_t !== 4'b0000 || o.rv_t !== 4'b0010 || o.prod_t !== 8'hFF) begin
            errors++; $display("FAIL taint_done: got g_t %b rv_t %b prod_t %h, required 0000 0010 ff", o.g_t, o.rv_t, o.prod_t);
        end
        mul_done_t = 1'b0;
        ref_ptr = 2;
    endtask

    task automatic test_random();
        obs_t o;
        int w;
        logic [N-1:0] r, rt, oh, m;
        logic [W-1:0] ea_t, eb_t;
        logic [PW-1:0] e, et;
        for (int i = 0; i < 20; i++) begin
            do r = 4'($urandom); while (r == '0);
            rt = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom);
            req_a = 16'($urandom); req_b = 16'($urandom);
            req_a_t = 16'($urandom); req_b_t = 16'($urandom);
            prod_t_cfg = 8'($urandom);
            w  = rr_pick(r, ref_ptr);
            oh = 4'(1 << w);
            m  = {N{|rt}};
            e  = PW'(req_a[w*W +: W]) * PW'(req_b[w*W +: W]);
            et = prod_t_cfg | {PW{|rt}};
            ea_t = req_a_t[w*W +: W] | {W{|rt}};
            eb_t = req_b_t[w*W +: W] | {W{|rt}};
            req = r; req_t = rt;
            run_txn(1'b1, 1'b0, 1'b0, o);
            checks++;
            if (o.g !== oh || o.rv !== oh || o.prod !== e) begin
                errors++; $display("FAIL rand_txn[%0d]: got grant %b resp %b prod %0d, required %b %b %0d", i, o.g, o.rv, o.prod, oh, oh, e);
            end
            checks++;
            if ({o.g_t, o.rv_t, o.ma_t, o.mb_t, o.prod_t} !== {oh & m, oh & m, ea_t, eb_t, et}) begin
                errors++; $display("FAIL rand_taint[%0d]: got %h, required %h", i, {o.g_t, o.rv_t, o.ma_t, o.mb_t, o.prod_t}, {oh & m, oh & m, ea_t, eb_t, et});
            end
            ref_ptr = (w + 1) % N;
        end
        req_t = '0; req_a_t = '0; req_b_t = '0; prod_t_cfg = '0;
    endtask

    task automatic test_stray();
        obs_t o;
        int w;
        bit bad;
        req = '0; tick(); tick();
        force_done = 1'b1; tick(); force_done = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (grant != '0 || resp_valid != '0 || mul_start) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stray_done: got activity after mul_done in IDLE, required none"); end
        w = rr_pick(4'b0001, ref_ptr);
        req_a[0 +: W] = 4'd7; req_b[0 +: W] = 4'd9;
        req = 4'b0001;
        run_txn(1'b0, 1'b1, 1'b1, o);
        checks++; if (o.rv !== 4'(1 << w) || o.timeout) begin errors++; $display("FAIL late_drop: got resp %b timeout %0d, required %b 0", o.rv, o.timeout, 4'(1 << w)); end
        checks++; if (o.prod !== 8'd63) begin errors++; $display("FAIL late_operand_change: got %0d, required 63", o.prod); end
        ref_ptr = (w + 1) % N;
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        int n;
        bit bad;
        req = 4'b0010;
        run_txn(1'b1, 1'b0, 1'b0, o);
        checks++; if (o.g !== 4'b0010) begin errors++; $display("FAIL rstwait_setup: got %b, required 0010", o.g); end
        req = 4'b0100;
        n = 0;
        do begin tick(); n++; end while (!(grant != '0 && !mul_start) && n < 10);
        checks++; if (grant !== 4'b0100 || mul_start !== 1'b0) begin errors++; $display("FAIL rstwait_in_wait: got grant %b start %b, required 0100 0", grant, mul_start); end
        rst = 1'b0; req = '0;
        tick();
        mdelay = 0;
        checks++; if ({grant, resp_valid, mul_a, mul_b} !== '0) begin errors++; $display("FAIL rstwait_idle: got %h, required 0", {grant, resp_valid, mul_a, mul_b}); end
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (resp_valid != '0) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL rstwait_no_resp: got resp_valid after reset, required none"); end
        ref_ptr = 0;
        req = 4'b1111;
        run_txn(1'b1, 1'b0, 1'b0, o);
        checks++; if (o.g !== 4'b0001) begin errors++; $display("FAIL rstwait_rr_ptr: got %b, required 0001", o.g); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; done_cyc = 0; mdelay = 0; ref_ptr = 0;
        force_done = 1'b0; prod_t_cfg = '0;
        rst = 1'b0; req = '0; req_t = '0;
        req_a = '0; req_a_t = '0; req_b = '0; req_b_t = '0;
        mul_done = 1'b0; mul_done_t = 1'b0; mul_product = '0; mul_product_t = '0;
        test_reset();
        test_single();
        test_fairness();
        test_taint();
        test_random();
        test_stray();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
